// File: rtl/sisc_pkg.sv
// sisc_pkg: SISC opcodes, instruction field positions, fetch state encoding and immediate width
package sisc_pkg;
  localparam logic [3:0] NOOP = 4'h0, ALU_OP = 4'h1, LOD = 4'h2, STR = 4'h3, BRA = 4'h4,
                         BRR = 4'h5, BNE = 4'h6, BNR = 4'h7, HLT = 4'hF;
  localparam int OP_HI = 31, MM_HI = 27, RD_HI = 23, RS_HI = 19, RT_HI = 15, IMM_HI = 15;
  localparam int IMM_W = 16;
  typedef enum logic [1:0] {IDLE, REQ, HOLD, PREF} fetch_state_t;
endpackage

// File: rtl/sisc_pc_unit.sv
// sisc_pc_unit: program counter register with sequential / absolute / relative next-pc selection
module sisc_pc_unit import sisc_pkg::*; #(
  parameter int AW = 16
) (
  input  logic             clk,
  input  logic             rst_f,
  input  logic             pc_update,
  input  logic             pc_sel,
  input  logic             br_sel,
  input  logic [IMM_W-1:0] imm,
  output logic [AW-1:0]    pc,
  output logic [AW-1:0]    pc_nxt
);
  always_comb pc_nxt = !pc_update ? pc : !pc_sel ? pc + 1'b1 : br_sel ? pc + AW'($signed(imm)) : AW'(imm);
  always_ff @(posedge clk or posedge rst_f)
    if (rst_f) pc <= '0;
    else pc <= pc_nxt;
endmodule

// File: rtl/sisc_fetch.sv
// sisc_fetch: SISC instruction fetch stage (pc, imem req/ack, ir, decode slices); SISC_FETCH_PREFETCH_EN adds a one-entry prefetch buffer
module sisc_fetch import sisc_pkg::*; #(
  parameter int AW = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          fetch_go,
  input  logic          pc_update,
  input  logic          pc_sel,
  input  logic          br_sel,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  output logic [31:0]   ir,
  output logic [3:0]    opcode,
  output logic [3:0]    mm,
  output logic [3:0]    rd,
  output logic [3:0]    rs,
  output logic [3:0]    rt,
  output logic [15:0]   imm,
  output logic [AW-1:0] pc,
  output logic          ir_valid,
  output logic          fetch_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  fetch_state_t state;
  logic [CW-1:0] wcnt;
  logic [AW-1:0] pc_nxt;
  logic to;
  sisc_pc_unit #(.AW(AW)) u_pc (
    .clk(clk), .rst_f(rst_f), .pc_update(pc_update), .pc_sel(pc_sel), .br_sel(br_sel),
    .imm(imm), .pc(pc), .pc_nxt(pc_nxt)
  );
  assign opcode = ir[OP_HI -: 4];
  assign mm = ir[MM_HI -: 4];
  assign rd = ir[RD_HI -: 4];
  assign rs = ir[RS_HI -: 4];
  assign rt = ir[RT_HI -: 4];
  assign imm = ir[IMM_HI -: IMM_W];
  assign to = !imem_ack && wcnt == CW'(TIMEOUT - 1);
`ifdef SISC_FETCH_PREFETCH_EN
  logic [31:0] pbuf;
  logic [AW-1:0] pbuf_addr;
  logic pbuf_valid, pf_kill, pend, br, hit;
  assign br = pc_update && pc_sel;
  assign hit = pbuf_valid && !br && pbuf_addr == pc_nxt;
`endif
  always_ff @(posedge clk or posedge rst_f)
    if (rst_f) begin
      state <= IDLE;
      wcnt <= '0;
      imem_req <= 1'b0;
      imem_addr <= '0;
      ir <= '0;
      ir_valid <= 1'b0;
      fetch_err <= 1'b0;
`ifdef SISC_FETCH_PREFETCH_EN
      pbuf <= '0;
      pbuf_addr <= '0;
      pbuf_valid <= 1'b0;
      pf_kill <= 1'b0;
      pend <= 1'b0;
`endif
    end else begin
      if (pc_update) ir_valid <= 1'b0;
      case (state)
        IDLE, HOLD: if (fetch_go) begin
          state <= REQ;
          imem_req <= 1'b1;
          imem_addr <= pc_nxt;
          wcnt <= '0;
          ir_valid <= 1'b0;
        end
        REQ: if (imem_ack) begin
          ir <= imem_rdata;
          ir_valid <= !pc_update && imem_addr == pc;
`ifdef SISC_FETCH_PREFETCH_EN
          state <= PREF;
          imem_addr <= imem_addr + 1'b1;
          wcnt <= '0;
          pbuf_valid <= 1'b0;
          pf_kill <= 1'b0;
          pend <= 1'b0;
`else
          state <= HOLD;
          imem_req <= 1'b0;
`endif
        end else if (to) begin
          state <= IDLE;
          imem_req <= 1'b0;
          fetch_err <= 1'b1;
        end else wcnt <= wcnt + 1'b1;
`ifdef SISC_FETCH_PREFETCH_EN
        PREF: if (imem_req) begin
          pf_kill <= pf_kill || br;
          pend <= pend || fetch_go;
          if (imem_ack) begin
            pbuf <= imem_rdata;
            pbuf_addr <= imem_addr;
          end
          if (imem_ack || to) begin
            imem_req <= 1'b0;
            if (pend || fetch_go) begin
              pend <= 1'b0;
              wcnt <= '0;
              imem_req <= 1'b1;
              if (imem_ack && !pf_kill && !br && imem_addr == pc_nxt) begin
                ir <= imem_rdata;
                ir_valid <= 1'b1;
                imem_addr <= imem_addr + 1'b1;
                pf_kill <= 1'b0;
              end else begin
                state <= REQ;
                imem_addr <= pc_nxt;
                ir_valid <= 1'b0;
              end
            end else pbuf_valid <= imem_ack && !pf_kill && !br;
          end else wcnt <= wcnt + 1'b1;
        end else begin
          if (br) pbuf_valid <= 1'b0;
          if (fetch_go) begin
            wcnt <= '0;
            imem_req <= 1'b1;
            if (hit) begin
              ir <= pbuf;
              ir_valid <= 1'b1;
              imem_addr <= pbuf_addr + 1'b1;
              pf_kill <= 1'b0;
              pbuf_valid <= 1'b0;
            end else begin
              state <= REQ;
              imem_addr <= pc_nxt;
              ir_valid <= 1'b0;
            end
          end
        end
`endif
        default: ;
      endcase
    end
endmodule

// File: tb/tb_sisc_fetch.sv
// tb_sisc_fetch: scoreboard bench for sisc_fetch with a stallable instruction memory model
module tb_sisc_fetch;
  logic clk = 1'b0, rst_f = 1'b1, fetch_go = 1'b0, pc_update = 1'b0, pc_sel = 1'b0, br_sel = 1'b0;
  logic imem_ack = 1'b0, imem_req, ir_valid, fetch_err;
  logic [31:0] imem_rdata = '0, ir;
  logic [15:0] imem_addr, pc, imm;
  logic [3:0] opcode, mm, rd, rs, rt;
  int checks = 0, errors = 0, stall = 0, wc = 0;
  bit block = 1'b0, force_ack = 1'b0, iv_q = 1'b0;
  logic [15:0] exp_addr[$], exp_pc[$];
  logic [31:0] exp_ir[$];
  sisc_fetch #(.AW(16), .TIMEOUT(15)) dut (
    .clk(clk), .rst_f(rst_f), .fetch_go(fetch_go), .pc_update(pc_update), .pc_sel(pc_sel),
    .br_sel(br_sel), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ir(ir), .opcode(opcode), .mm(mm), .rd(rd), .rs(rs), .rt(rt),
    .imm(imm), .pc(pc), .ir_valid(ir_valid), .fetch_err(fetch_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask
  function automatic logic [31:0] word(input logic [15:0] a);
    return a == 16'h0 ? 32'h81230000 : a == 16'h1 ? 32'h40000010 : a == 16'h10 ? 32'h5000FFFE : {16'hC0DE, a};
  endfunction
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic go();
    fetch_go = 1'b1;
    tick(1);
    fetch_go = 1'b0;
  endtask
  task automatic upd(input bit s, input bit b);
    pc_update = 1'b1;
    pc_sel = s;
    br_sel = b;
    tick(1);
    pc_update = 1'b0;
  endtask
  task automatic expect_fetch(input logic [15:0] a, input logic [31:0] w);
    exp_addr.push_back(a);
    exp_ir.push_back(w);
    exp_pc.push_back(a);
`ifdef SISC_FETCH_PREFETCH_EN
    exp_addr.push_back(a + 16'h1);
`endif
  endtask
  task automatic wait_valid(input int lat);
    int n = 1;
    while (!ir_valid && n < 12) begin
      tick(1);
      n++;
    end
    chk("fetch_latency", n, lat);
  endtask
  always @(negedge clk) begin
    if (imem_req && !block && wc >= stall) begin
      imem_ack = 1'b1;
      imem_rdata = word(imem_addr);
      wc = 0;
      if (exp_addr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL req_unexpected actual=%0h required=none", imem_addr);
      end else chk("req_addr", imem_addr, exp_addr.pop_front());
    end else begin
      imem_ack = force_ack;
      imem_rdata = force_ack ? 32'hDEADBEEF : 32'h0;
      wc = imem_req ? wc + 1 : 0;
    end
    if (ir_valid && !iv_q) begin
      if (exp_ir.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ir_unexpected actual=%0h required=none", ir);
      end else begin
        chk("ir_load", ir, exp_ir.pop_front());
        chk("ir_pc", pc, exp_pc.pop_front());
      end
    end
    iv_q = ir_valid;
  end
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    tick(2);
    rst_f = 1'b0;
    @(negedge clk);
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir, 0);
    chk("rst_ir_valid", ir_valid, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_err", fetch_err, 0);
    tick(1);
    expect_fetch(16'h0, 32'h81230000);
    go();
    wait_valid(2);
    chk("dec_opcode", opcode, 4'h8);
    chk("dec_mm", mm, 4'h1);
    chk("dec_rd", rd, 4'h2);
    chk("dec_rs", rs, 4'h3);
    chk("dec_rt", rt, 4'h0);
    tick(4);
    stall = 2;
    expect_fetch(16'h0, 32'h81230000);
    go();
    wait_valid(4);
    tick(8);
    stall = 0;
    upd(1'b0, 1'b0);
    chk("seq_pc1", pc, 16'h1);
    chk("upd_clears_valid", ir_valid, 0);
`ifdef SISC_FETCH_PREFETCH_EN
    exp_ir.push_back(32'h40000010);
    exp_pc.push_back(16'h1);
    exp_addr.push_back(16'h2);
    go();
    wait_valid(1);
`else
    expect_fetch(16'h1, 32'h40000010);
    go();
    wait_valid(2);
`endif
    tick(4);
    upd(1'b1, 1'b0);
    chk("abs_pc10", pc, 16'h0010);
    expect_fetch(16'h10, 32'h5000FFFE);
    go();
    wait_valid(2);
    chk("dec_imm", imm, 16'hFFFE);
    tick(4);
    upd(1'b1, 1'b1);
    chk("rel_pc0e", pc, 16'h000E);
    upd(1'b1, 1'b0);
    chk("abs_pcfffe", pc, 16'hFFFE);
    upd(1'b0, 1'b0);
    chk("seq_pcffff", pc, 16'hFFFF);
    upd(1'b0, 1'b0);
    chk("seq_wrap", pc, 16'h0000);
    repeat (5) upd(1'b0, 1'b0);
    chk("seq_pc5", pc, 16'h5);
    expect_fetch(16'h6, 32'hC0DE0006);
    fetch_go = 1'b1;
    pc_update = 1'b1;
    pc_sel = 1'b0;
    tick(1);
    fetch_go = 1'b0;
    pc_update = 1'b0;
    chk("same_cycle_addr", imem_addr, 16'h6);
    wait_valid(2);
    tick(4);
    block = 1'b1;
    go();
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (!imem_req) break;
      n++;
    end
    chk("timeout_req_cycles", n, 15);
    chk("timeout_err", fetch_err, 1);
    chk("timeout_req_drop", imem_req, 0);
    force_ack = 1'b1;
    tick(3);
    force_ack = 1'b0;
    chk("late_ack_ir", ir, 32'hC0DE0006);
    chk("late_ack_valid", ir_valid, 0);
    block = 1'b0;
    expect_fetch(16'h6, 32'hC0DE0006);
    go();
    wait_valid(2);
    chk("err_sticky", fetch_err, 1);
    tick(4);
    block = 1'b1;
    go();
    tick(2);
    @(negedge clk);
    chk("midreq_req", imem_req, 1);
    #2 rst_f = 1'b1;
    #1;
    chk("async_rst_req", imem_req, 0);
    chk("async_rst_pc", pc, 0);
    chk("async_rst_ir", ir, 0);
    chk("async_rst_valid", ir_valid, 0);
    chk("async_rst_err", fetch_err, 0);
    chk("async_rst_addr", imem_addr, 0);
    tick(1);
    rst_f = 1'b0;
    block = 1'b0;
    tick(2);
    chk("post_rst_req", imem_req, 0);
    chk("addr_queue_left", exp_addr.size(), 0);
    chk("ir_queue_left", exp_ir.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
